// File: rtl/capture_readout_ctrl_if.sv
// capture_readout_ctrl_if: capture FIFO pop side, byte stream to the UART and run control/status.
interface capture_readout_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Arm;
  logic             Abort;
  logic             DataReady;
  logic             DataValid;
  logic [31:0]      DataIn;
  logic             RdEn;
  logic [7:0]       TxData;
  logic             TxValid;
  logic             TxReady;
  logic             Busy;
  logic             Done;
  logic             Error;
  logic [CNT_W-1:0] WordCount;
  modport master (
    input  Arm, Abort, DataReady, DataValid, DataIn, TxReady,
    output RdEn, TxData, TxValid, Busy, Done, Error, WordCount
  );
  modport slave (
    output Arm, Abort, DataReady, DataValid, DataIn, TxReady,
    input  RdEn, TxData, TxValid, Busy, Done, Error, WordCount
  );
endinterface

// File: rtl/capture_readout_ctrl.sv
// capture_readout_ctrl: drains NUM_WORDS words from the capture FIFO and streams them MSB-byte-first.
module capture_readout_ctrl #(
  parameter int NUM_WORDS     = 256,
  parameter int CNT_W         = 16,
  parameter int VALID_TIMEOUT = 15
) (
  input logic SysClk,
  input logic Reset,
  capture_readout_ctrl_if.master bus
);
  localparam int TW = $clog2(VALID_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_READY, READ, WAIT_VALID, SEND, DONE} state_t;
  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic             last_word;
  assign last_word = wcnt_q == CNT_W'(NUM_WORDS - 1);
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      byte_idx_q <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    if (bus.Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.Arm) begin
          state_d = WAIT_READY;
          wcnt_d  = '0;
          err_d   = 1'b0;
        end
        WAIT_READY: state_d = bus.DataReady ? READ : WAIT_READY;
        READ: begin
          state_d = WAIT_VALID;
          cnt_d   = '0;
        end
        // A valid response wins over a timeout landing in the same cycle
        WAIT_VALID: if (bus.DataValid) begin
          word_d     = bus.DataIn;
          byte_idx_d = '0;
          state_d    = SEND;
        end else if (cnt_q == TW'(VALID_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        SEND: if (bus.TxReady) begin
          word_d     = word_q << 8;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = last_word ? DONE : WAIT_READY;
            wcnt_d  = last_word ? wcnt_q : wcnt_q + 1'b1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // The word shifts left on each accepted byte, so the top byte is always the one on offer
  assign bus.RdEn      = state_q == READ;
  assign bus.TxValid   = state_q == SEND;
  assign bus.TxData    = state_q == SEND ? word_q[31:24] : 8'h00;
  assign bus.Busy      = state_q != IDLE;
  assign bus.Done      = state_q == DONE;
  assign bus.Error     = err_q;
  assign bus.WordCount = wcnt_q;
endmodule

// File: tb/tb_capture_readout_ctrl.sv
// tb_capture_readout_ctrl: FIFO/transmitter models around the readout controller, scored against
// a stream model built from the drained words.
module tb_capture_readout_ctrl;
  localparam int NW = 4;
  localparam int VT = 15;
  localparam int CW = 16;
  typedef struct {
    int period;
    int dly;
    int gap_after;
    int gap_len;
    int exp_bytes;
    int exp_rd;
    int exp_done;
    int exp_err;
  } scn_t;
  logic SysClk;
  logic Reset;
  capture_readout_ctrl_if #(.CNT_W(CW)) bus();
  capture_readout_ctrl #(.NUM_WORDS(NW), .CNT_W(CW), .VALID_TIMEOUT(VT)) dut (
    .SysClk(SysClk),
    .Reset (Reset),
    .bus   (bus)
  );
  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;
  int n_chk, n_fail;
  int cyc, pop_idx, dv_cnt, gap_cnt, gap_after, gap_len, rd_cnt, done_cnt, tx_period;
  bit tx_force_low, dr_rand, arm_rand, hold_prev;
  logic [7:0]  data_prev;
  logic [7:0]  got[$];
  logic [31:0] words[NW];
  int          dlys[NW];
  scn_t        scns[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic init_env(input int period);
    cyc = 0; pop_idx = 0; dv_cnt = 0; gap_cnt = 0; gap_after = -1; gap_len = 0;
    rd_cnt = 0; done_cnt = 0; got.delete(); hold_prev = 0; tx_period = period;
    tx_force_low = 0; dr_rand = 0; arm_rand = 0;
    for (int i = 0; i < NW; i++) begin
      words[i] = 32'h00010203 + 32'h04040404 * 32'(i);
      dlys[i]  = 1;
    end
    bus.DataReady = 1; bus.DataValid = 0; bus.DataIn = '0;
    bus.Abort = 0; bus.Arm = 0; bus.TxReady = 1;
  endtask
  // One cycle: observe at the falling edge, then drive inputs for the next rising edge
  task automatic step();
    @(negedge SysClk);
    cyc++;
    if (hold_prev && !bus.Abort) begin
      chk("tx_hold_valid", 64'(bus.TxValid), 64'd1);
      chk("tx_hold_data", 64'(bus.TxData), 64'(data_prev));
    end
    if (bus.RdEn) begin
      rd_cnt++;
      chk("rden_after_ready", 64'(bus.DataReady), 64'd1);
      chk("one_outstanding", 64'(dv_cnt), 64'd0);
    end
    if (bus.Done) done_cnt++;
    bus.DataIn    = words[pop_idx % NW];
    bus.DataValid = (dv_cnt == 1);
    if (dv_cnt > 0) dv_cnt--;
    if (bus.DataValid) begin
      pop_idx++;
      if (pop_idx == gap_after) gap_cnt = gap_len;
    end
    if (bus.RdEn) dv_cnt = dlys[pop_idx % NW];
    bus.DataReady = (gap_cnt == 0) && (!dr_rand || $urandom_range(0, 1) == 1);
    if (gap_cnt > 0) gap_cnt--;
    bus.TxReady = !tx_force_low &&
                  (tx_period == 0 ? ($urandom_range(0, 1) == 1) : (cyc % tx_period == 0));
    bus.Arm   = arm_rand && bus.Busy && ($urandom_range(0, 3) == 0);
    bus.Abort = 0;
    if (bus.TxValid && bus.TxReady) got.push_back(bus.TxData);
    hold_prev = bus.TxValid && !bus.TxReady;
    data_prev = bus.TxData;
  endtask
  task automatic arm_run(input string tag);
    int n;
    bus.Arm = 1;
    step();
    chk({tag, "_arm_wc"}, 64'(bus.WordCount), 64'd0);
    chk({tag, "_arm_err"}, 64'(bus.Error), 64'd0);
    chk({tag, "_arm_busy"}, 64'(bus.Busy), 64'd1);
    n = 0;
    while (bus.Busy && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 64'(bus.Busy), 64'd0);
  endtask
  task automatic check_result(input string tag, input int en, input int erd, input int edone,
                              input int eerr);
    chk({tag, "_nbytes"}, 64'(got.size()), 64'(en));
    for (int k = 0; k < en && k < got.size(); k++)
      chk({tag, "_byte"}, 64'(got[k]), 64'(words[k / 4][8 * (3 - k % 4) +: 8]));
    chk({tag, "_rden"}, 64'(rd_cnt), 64'(erd));
    chk({tag, "_done"}, 64'(done_cnt), 64'(edone));
    chk({tag, "_error"}, 64'(bus.Error), 64'(eerr));
  endtask
  function automatic logic [28:0] outs();
    return {bus.RdEn, bus.TxValid, bus.Busy, bus.Done, bus.Error, bus.TxData, bus.WordCount};
  endfunction
  initial begin
    int n, e;
    n_chk = 0;
    n_fail = 0;
    scns[0] = '{1, 1, -1, 0, 16, 4, 1, 0};
    scns[1] = '{3, 1, -1, 0, 16, 4, 1, 0};
    scns[2] = '{1, 1, 2, 20, 16, 4, 1, 0};
    scns[3] = '{2, VT, -1, 0, 16, 4, 1, 0};
    scns[4] = '{1, 0, -1, 0, 0, 1, 0, 1};
    scns[5] = '{1, VT + 1, -1, 0, 0, 1, 0, 1};
    scns[6] = '{1, 2, 1, 5, 16, 4, 1, 0};
    Reset = 1;
    init_env(1);
    repeat (2) @(negedge SysClk);
    chk("reset_outputs", 64'(outs()), 64'd0);
    Reset = 0;
    step();
    chk("idle_after_reset", 64'(outs()), 64'd0);
    for (int s = 0; s < 7; s++) begin
      init_env(scns[s].period);
      for (int i = 0; i < NW; i++) dlys[i] = scns[s].dly;
      gap_after = scns[s].gap_after;
      gap_len   = scns[s].gap_len;
      arm_run($sformatf("scn%0d", s));
      check_result($sformatf("scn%0d", s), scns[s].exp_bytes, scns[s].exp_rd,
                   scns[s].exp_done, scns[s].exp_err);
    end
    // Arm-to-RdEn latency and exact timeout instant, DataValid withheld
    init_env(1);
    for (int i = 0; i < NW; i++) dlys[i] = 0;
    bus.Arm = 1;
    step();
    chk("lat_rden_early", 64'(bus.RdEn), 64'd0);
    step();
    chk("lat_rden", 64'(bus.RdEn), 64'd1);
    repeat (VT) step();
    chk("tmo_err_early", 64'(bus.Error), 64'd0);
    chk("tmo_busy_early", 64'(bus.Busy), 64'd1);
    step();
    chk("tmo_err", 64'(bus.Error), 64'd1);
    chk("tmo_busy", 64'(bus.Busy), 64'd0);
    chk("tmo_done", 64'(done_cnt), 64'd0);
    bus.Arm = 1;
    bus.Abort = 1;
    step();
    chk("arm_abort_busy", 64'(bus.Busy), 64'd0);
    chk("arm_abort_err", 64'(bus.Error), 64'd1);
    // Abort while the third byte of word 0 is on offer
    init_env(1);
    bus.Arm = 1;
    step();
    n = 0;
    while (got.size() < 2 && n < 200) begin
      step();
      n++;
    end
    chk("abort_reach", 64'(got.size()), 64'd2);
    tx_force_low = 1;
    step();
    chk("abort_pre_valid", 64'(bus.TxValid), 64'd1);
    chk("abort_pre_data", 64'(bus.TxData), 64'h02);
    bus.Abort = 1;
    step();
    chk("abort_txvalid", 64'(bus.TxValid), 64'd0);
    chk("abort_busy", 64'(bus.Busy), 64'd0);
    chk("abort_done", 64'(done_cnt), 64'd0);
    chk("abort_err", 64'(bus.Error), 64'd0);
    init_env(1);
    arm_run("rearm");
    check_result("rearm", 16, 4, 1, 0);
    // Asynchronous reset between edges while waiting on word 2
    init_env(1);
    dlys[2] = 0;
    bus.Arm = 1;
    step();
    n = 0;
    while (!(rd_cnt == 3 && !bus.RdEn) && n < 500) begin
      step();
      n++;
    end
    chk("rst_pre_busy", 64'(bus.Busy), 64'd1);
    chk("rst_pre_wc", 64'(bus.WordCount), 64'd2);
    #2 Reset = 1;
    #1 chk("rst_async_outputs", 64'(outs()), 64'd0);
    @(negedge SysClk);
    Reset = 0;
    init_env(3);
    arm_run("post_rst");
    check_result("post_rst", 16, 4, 1, 0);
    // Random words, delays, readiness and stray Arm pulses against the stream model
    for (int r = 0; r < 10; r++) begin
      int u;
      init_env(0);
      dr_rand  = 1;
      arm_rand = 1;
      for (int i = 0; i < NW; i++) begin
        words[i] = $urandom;
        u = int'($urandom_range(0, 9));
        dlys[i] = u == 0 ? VT + 1 : u == 1 ? VT : int'($urandom_range(1, 4));
      end
      e = NW;
      for (int i = NW - 1; i >= 0; i--) if (dlys[i] > VT) e = i;
      arm_run($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r), 4 * e, e < NW ? e + 1 : NW, e == NW ? 1 : 0,
                   e < NW ? 1 : 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
